fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the 256×8 combinational instruction memory and directly downstream-feeds the decoder.
- Owns the program counter and drives the memory address.
- Captures the returned byte into an instruction register (IR) and presents it to the decoder with a valid/ready handshake.
- Handles branch/jump redirects with a one-slot flush and stops fetching on a HALT opcode.

Parameters:
- ADDR_W, 8, PC/memory address width (256-entry memory).
- INSTR_W, 8, instruction width.
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_OPCODE, 8'hFF, instruction byte that stops fetching.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  ADDR_W  address to instruction memory; equals PC, combinational from the PC register.
- imem_instr  input  INSTR_W  combinational read data from instruction memory for imem_addr.
- ir_instr  output  INSTR_W  registered instruction to decoder.
- ir_pc  output  ADDR_W  address ir_instr was fetched from.
- ir_valid  output  1  ir_instr/ir_pc hold an unconsumed instruction.
- ir_ready  input  1  decoder accepts IR this cycle; transfer occurs when ir_valid && ir_ready.
- redirect  input  1  taken branch/jump; single-cycle pulse.
- redirect_target  input  ADDR_W  new PC when redirect=1.
- halted  output  1  fetch stopped by HALT_OPCODE.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values, applied immediately on rst=1 regardless of clk:
  - pc=RESET_PC, ir_instr=0, ir_pc=0, ir_valid=0, halted=0.
  - State=RUN, so imem_addr=RESET_PC.
- States:
  - RUN: fetching.
  - HALT: no fetches. HALT is sticky until rst.
- Slot free: slot_free = !ir_valid || ir_ready.
- Priority at each rising edge, highest first:
  1. redirect=1 in RUN: pc<=redirect_target, ir_valid<=0 (flush, even if the IR was not accepted), ir_instr/ir_pc hold stale values. No fetch this edge, so a redirect costs exactly one bubble. If the current IR is being accepted on the same edge, the transfer still counts as completed.
  2. RUN && slot_free: fetch. ir_instr<=imem_instr, ir_pc<=pc, ir_valid<=1.
     - If imem_instr==HALT_OPCODE: pc holds and state<=HALT. halted=1 from the next cycle.
     - Otherwise: pc<=pc+1, mod 2^ADDR_W, so 8'hFF wraps to 8'h00.
  3. RUN && !slot_free (stall): pc, ir_instr, ir_pc, ir_valid all hold. No skipped or duplicated instructions.
  4. HALT: pc and IR hold. ir_valid clears when accepted (ir_valid && ir_ready) and then stays 0. redirect is ignored.
- Redirect vs. HALT fetch: if redirect coincides with the edge that would fetch HALT_OPCODE, redirect wins and no halt occurs.
- Latency and throughput:
  - PC to IR: one cycle.
  - With ir_ready held high, throughput is 1 instruction/cycle.
  - First valid instruction is mem[RESET_PC], on the first rising edge after rst deasserts.
- Widths: all PC arithmetic is unsigned ADDR_W; the carry out is discarded.
- Reset mid-operation: outputs return to reset values asynchronously. Any in-flight IR content is lost with no handshake.

Decomposition:
- Shared package cpu_pkg holds:
  - constants ADDR_W, INSTR_W, HALT_OPCODE;
  - the fetch-state enum {FETCH_RUN, FETCH_HALT}.
  The decoder reuses these.
- One sub-module, pc_reg: PC register with async reset to RESET_PC and a prioritised load/increment/hold control.
- The IR, handshake and state machine stay in fetch_unit.

Test Plan:
1. Reset:
   - Assert rst mid-stream with ir_valid=1 and pc=0x23, then release.
   - Immediately without a clock edge: ir_valid=0, halted=0, imem_addr=0x00.
   - After the first edge post-release: ir_instr=mem[0], ir_pc=0x00, ir_valid=1.
2. Streaming:
   - mem[0..3]=0x11,0x22,0x33,0x44, ir_ready=1.
   - Edges 1..4 give ir_instr 0x11,0x22,0x33,0x44 with ir_pc 0..3; ir_valid is 1 continuously.
3. Backpressure:
   - Hold ir_ready=0 for 3 cycles after 0x11 is loaded.
   - ir_instr stays 0x11, ir_pc stays 0x00, imem_addr stays 0x01.
   - Raise ir_ready: next values are 0x22 then 0x33, with no skip or duplicate.
4. Redirect:
   - With ir_pc=0x01 valid, pulse redirect with target 0x80.
   - Next cycle: ir_valid=0, imem_addr=0x80.
   - Following cycle: ir_instr=mem[0x80], ir_pc=0x80, ir_valid=1.
5. Wrap:
   - Redirect to 0xFF with mem[0xFF]=0x05 and mem[0x00]=0x11.
   - Produces ir_pc=0xFF / ir_instr=0x05, then ir_pc=0x00 / ir_instr=0x11.
6. Halt:
   - mem[5]=0xFF, ir_ready=1.
   - ir_instr=0xFF with ir_pc=0x05; halted=1 from the next cycle; imem_addr frozen at 0x05.
   - ir_valid drops after acceptance and stays 0.
   - A later redirect to 0x10 is ignored; halted stays 1 until rst.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-state encoding, common to the fetch unit and the decoder.
package cpu_pkg;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned INSTR_W     = 8;
  localparam logic [7:0]  HALT_OPCODE = 8'hFF;

  typedef enum logic [0:0] {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/pc_reg.sv
// Program counter register: async reset to RESET_PC, then load > increment > hold.
module pc_reg #(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      // Natural ADDR_W-bit wrap; carry out is dropped.
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC into a combinational imem, captures the byte into the IR
// and hands it to the decoder with valid/ready; redirects flush the IR, HALT_OPCODE stops fetching.
module fetch_unit #(
  parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = INSTR_W'(cpu_pkg::HALT_OPCODE)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] ir_instr,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               halted
);
  import cpu_pkg::*;

  fetch_state_e       state_d, state_q;
  logic [INSTR_W-1:0] ir_instr_d, ir_instr_q;
  logic [ADDR_W-1:0]  ir_pc_d, ir_pc_q;
  logic               ir_valid_d, ir_valid_q;
  logic [ADDR_W-1:0]  pc;
  logic               pc_load;
  logic               pc_inc;
  logic               slot_free;
  logic               accept;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (redirect_target),
    .inc      (pc_inc),
    .pc       (pc)
  );

  assign slot_free = !ir_valid_q || ir_ready;
  assign accept    = ir_valid_q && ir_ready;

  always_comb begin
    state_d    = state_q;
    ir_instr_d = ir_instr_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    case (state_q)
      FETCH_RUN: begin
        if (redirect) begin
          // Flush without fetching: the wrong-path slot becomes a single bubble.
          pc_load    = 1'b1;
          ir_valid_d = 1'b0;
        end else if (slot_free) begin
          ir_instr_d = imem_instr;
          ir_pc_d    = pc;
          ir_valid_d = 1'b1;
          if (imem_instr == HALT_OPCODE) begin
            state_d = FETCH_HALT;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      FETCH_HALT: begin
        if (accept) begin
          ir_valid_d = 1'b0;
        end
      end
      default: state_d = FETCH_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH_RUN;
      ir_instr_q <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_instr_q <= ir_instr_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign imem_addr = pc;
  assign ir_instr  = ir_instr_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign halted    = (state_q == FETCH_HALT);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural 256x8 combinational instruction memory.
module tb_fetch_unit;
  logic       clk;
  logic       rst;
  logic [7:0] imem_addr;
  logic [7:0] imem_instr;
  logic [7:0] ir_instr;
  logic [7:0] ir_pc;
  logic       ir_valid;
  logic       ir_ready;
  logic       redirect;
  logic [7:0] redirect_target;
  logic       halted;

  logic [7:0] mem [256];
  int n_checks;
  int n_errors;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .ir_instr        (ir_instr),
    .ir_pc           (ir_pc),
    .ir_valid        (ir_valid),
    .ir_ready        (ir_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halted          (halted)
  );

  assign imem_instr = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ir(input string tag, input logic [7:0] instr, input logic [7:0] pc,
                          input logic vld);
    check({tag, "_instr"}, 16'(ir_instr), 16'(instr));
    check({tag, "_pc"},    16'(ir_pc),    16'(pc));
    check({tag, "_valid"}, 16'(ir_valid), 16'(vld));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
    mem[8'h04] = 8'h55; mem[8'h05] = 8'hFF; mem[8'h22] = 8'h9C;
    mem[8'h80] = 8'hA5; mem[8'h81] = 8'hA6; mem[8'hFF] = 8'h05; mem[8'h10] = 8'h77;

    rst = 1'b1; ir_ready = 1'b0; redirect = 1'b0; redirect_target = 8'h00;
    tick();
    tick();
    check("rst_valid", 16'(ir_valid), 16'h0);
    check("rst_addr",  16'(imem_addr), 16'h00);
    rst = 1'b0;
    ir_ready = 1'b1;

    // Streaming at one instruction per cycle.
    tick(); check_ir("s1", 8'h11, 8'h00, 1'b1);
    tick(); check_ir("s2", 8'h22, 8'h01, 1'b1);
    tick(); check_ir("s3", 8'h33, 8'h02, 1'b1);
    tick(); check_ir("s4", 8'h44, 8'h03, 1'b1);

    // Get to pc=0x23 with a valid IR, then reset mid-stream.
    redirect = 1'b1; redirect_target = 8'h22;
    tick();
    check("r22_valid", 16'(ir_valid), 16'h0);
    check("r22_addr",  16'(imem_addr), 16'h22);
    redirect = 1'b0;
    tick();
    check_ir("f22", 8'h9C, 8'h22, 1'b1);
    check("f22_addr", 16'(imem_addr), 16'h23);
    ir_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_valid",  16'(ir_valid),  16'h0);
    check("arst_halted", 16'(halted),    16'h0);
    check("arst_addr",   16'(imem_addr), 16'h00);
    check("arst_instr",  16'(ir_instr),  16'h00);
    check("arst_pc",     16'(ir_pc),     16'h00);
    #1 rst = 1'b0;

    // First fetch after reset, then backpressure for three cycles.
    tick(); check_ir("pr", 8'h11, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ir("bp", 8'h11, 8'h00, 1'b1);
      check("bp_addr", 16'(imem_addr), 16'h01);
    end
    ir_ready = 1'b1;
    tick(); check_ir("bp_r1", 8'h22, 8'h01, 1'b1);
    tick(); check_ir("bp_r2", 8'h33, 8'h02, 1'b1);

    // Redirect while the IR is not being accepted: still flushed.
    ir_ready = 1'b0; redirect = 1'b1; redirect_target = 8'h80;
    tick();
    check("rd_valid", 16'(ir_valid), 16'h0);
    check("rd_addr",  16'(imem_addr), 16'h80);
    redirect = 1'b0; ir_ready = 1'b1;
    tick(); check_ir("rd_f1", 8'hA5, 8'h80, 1'b1);
    tick(); check_ir("rd_f2", 8'hA6, 8'h81, 1'b1);

    // PC wrap from 0xFF to 0x00.
    redirect = 1'b1; redirect_target = 8'hFF;
    tick();
    check("wr_valid", 16'(ir_valid), 16'h0);
    redirect = 1'b0;
    tick(); check_ir("wr_ff", 8'h05, 8'hFF, 1'b1);
    check("wr_addr", 16'(imem_addr), 16'h00);
    tick(); check_ir("wr_00", 8'h11, 8'h00, 1'b1);

    // Redirect on the edge that would fetch HALT_OPCODE wins.
    redirect = 1'b1; redirect_target = 8'h05;
    tick();
    check("hr_addr", 16'(imem_addr), 16'h05);
    redirect_target = 8'h04;
    tick();
    check("hr_halted", 16'(halted), 16'h0);
    check("hr_valid",  16'(ir_valid), 16'h0);
    check("hr_addr2",  16'(imem_addr), 16'h04);
    redirect = 1'b0;
    tick(); check_ir("h55", 8'h55, 8'h04, 1'b1);
    check("h55_halted", 16'(halted), 16'h0);

    // Real halt.
    tick(); check_ir("hff", 8'hFF, 8'h05, 1'b1);
    check("hff_halted", 16'(halted), 16'h1);
    check("hff_addr",   16'(imem_addr), 16'h05);
    tick();
    check("hacc_valid",  16'(ir_valid),  16'h0);
    check("hacc_halted", 16'(halted),    16'h1);
    check("hacc_addr",   16'(imem_addr), 16'h05);
    redirect = 1'b1; redirect_target = 8'h10;
    tick();
    redirect = 1'b0;
    check("hrd_addr",   16'(imem_addr), 16'h05);
    check("hrd_valid",  16'(ir_valid),  16'h0);
    check("hrd_halted", 16'(halted),    16'h1);
    tick();
    check_ir("hhold", 8'hFF, 8'h05, 1'b0);
    check("hhold_halted", 16'(halted), 16'h1);

    rst = 1'b1;
    #1;
    check("hrst_halted", 16'(halted),    16'h0);
    check("hrst_addr",   16'(imem_addr), 16'h00);
    #1 rst = 1'b0;
    tick(); check_ir("hrst_f", 8'h11, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
